// File: rtl/lcd_square_if.sv
// Bus between the frame-timing side and the moving-square controller.
// The controller sits on the slave modport; the stimulus/host side is the master.
interface lcd_square_if;
  logic       vga_vs;
  logic       enable;
  logic [3:0] step;
  logic [3:0] frame_div;
  logic [9:0] sq_x;
  logic [8:0] sq_y;
  logic       dir_x;
  logic       dir_y;
  logic       frame_upd;
  logic       busy;

  modport master (
    output vga_vs, enable, step, frame_div,
    input  sq_x, sq_y, dir_x, dir_y, frame_upd, busy
  );

  modport slave (
    input  vga_vs, enable, step, frame_div,
    output sq_x, sq_y, dir_x, dir_y, frame_upd, busy
  );
endinterface

// File: rtl/lcd_square_ctrl.sv
// Moves a square around the visible LCD area once every frame_div+1 frames.
// Define SQ_CTRL_WRAP_EN to make the square wrap at the edges instead of bouncing.
module lcd_square_ctrl #(
  parameter int SCREEN_X = 480,
  parameter int SCREEN_Y = 272,
  parameter int SQUARE_X = 150,
  parameter int SQUARE_Y = 150
) (
  input  logic        clk,
  input  logic        rst_n,
  lcd_square_if.slave bus
);

  localparam logic [10:0] LIM_X = 11'(SCREEN_X - SQUARE_X);
  localparam logic [10:0] LIM_Y = 11'(SCREEN_Y - SQUARE_Y);
  localparam logic [9:0]  RST_X = 10'((SCREEN_X - SQUARE_X) / 2);
  localparam logic [8:0]  RST_Y = 9'((SCREEN_Y - SQUARE_Y) / 2);

  typedef enum logic [2:0] {IDLE, WAIT_VS, CALC_X, CALC_Y, COMMIT} state_t;

  // Returns {new_dir, new_pos}; 11-bit math keeps pos+step clear of overflow.
  function automatic logic [11:0] move_axis(input logic [10:0] pos, input logic [3:0] stp,
                                            input logic dir, input logic [10:0] lim);
    logic [10:0] s;
    logic [10:0] np;
    logic        nd;
    s  = {7'd0, stp};
    np = pos;
    nd = dir;
`ifdef SQ_CTRL_WRAP_EN
    if (dir) begin
      if (pos + s > lim) np = pos + s - lim - 11'd1;
      else               np = pos + s;
    end else begin
      if (pos < s) np = pos + lim + 11'd1 - s;
      else         np = pos - s;
    end
`else
    if (s != 11'd0) begin
      if (dir) begin
        if (pos + s >= lim) begin
          np = lim;
          nd = 1'b0;
        end else begin
          np = pos + s;
        end
      end else begin
        if (pos <= s) begin
          np = 11'd0;
          nd = 1'b1;
        end else begin
          np = pos - s;
        end
      end
    end
`endif
    return {nd, np};
  endfunction

  state_t      state;
  logic        vs_p0, vs_p1, vs_p2;
  logic [3:0]  frame_cnt;
  logic [9:0]  sq_x;
  logic [8:0]  sq_y;
  logic        dir_x, dir_y;
  logic        frame_upd, busy;
  logic [3:0]  step_p0;
  logic [10:0] pos_x_p1, pos_y_p2;
  logic        dir_x_p1, dir_y_p2;
  logic        frame_start;
  logic        go_calc;

  assign frame_start = vs_p2 & ~vs_p1;
  assign go_calc     = (state == WAIT_VS) && bus.enable && frame_start &&
                       (frame_cnt == bus.frame_div);

  // Control: synchronizer, FSM, frame counter and committed outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_p0     <= 1'b1;
      vs_p1     <= 1'b1;
      vs_p2     <= 1'b1;
      state     <= IDLE;
      frame_cnt <= 4'd0;
      sq_x      <= RST_X;
      sq_y      <= RST_Y;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      frame_upd <= 1'b0;
      busy      <= 1'b0;
    end else begin
      vs_p0     <= bus.vga_vs;
      vs_p1     <= vs_p0;
      vs_p2     <= vs_p1;
      frame_upd <= 1'b0;
      case (state)
        IDLE: begin
          frame_cnt <= 4'd0;
          if (bus.enable) state <= WAIT_VS;
        end
        WAIT_VS: begin
          if (!bus.enable) begin
            state <= IDLE;
          end else if (go_calc) begin
            frame_cnt <= 4'd0;
            state     <= CALC_X;
            busy      <= 1'b1;
          end else if (frame_start) begin
            frame_cnt <= frame_cnt + 4'd1;
          end
        end
        CALC_X: state <= CALC_Y;
        CALC_Y: state <= COMMIT;
        COMMIT: begin
          sq_x      <= 10'(pos_x_p1);
          sq_y      <= 9'(pos_y_p2);
          dir_x     <= dir_x_p1;
          dir_y     <= dir_y_p2;
          frame_upd <= 1'b1;
          busy      <= 1'b0;
          state     <= bus.enable ? WAIT_VS : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Datapath: p0 step capture, p1 X shadow, p2 Y shadow
  always_ff @(posedge clk) begin
    if (go_calc) step_p0 <= bus.step;
    if (state == CALC_X)
      {dir_x_p1, pos_x_p1} <= move_axis({1'b0, sq_x}, step_p0, dir_x, LIM_X);
    if (state == CALC_Y)
      {dir_y_p2, pos_y_p2} <= move_axis({2'b00, sq_y}, step_p0, dir_y, LIM_Y);
  end

  assign bus.sq_x      = sq_x;
  assign bus.sq_y      = sq_y;
  assign bus.dir_x     = dir_x;
  assign bus.dir_y     = dir_y;
  assign bus.frame_upd = frame_upd;
  assign bus.busy      = busy;

endmodule

// File: tb/tb_lcd_square_ctrl.sv
// Bench for lcd_square_ctrl: directed corner cases plus random frames against
// a frame-level model of the square's motion.
module tb_lcd_square_ctrl;

  localparam int LX = 330;
  localparam int LY = 122;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_square_if bus ();

  lcd_square_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int mx, my, mdx, mdy, mcnt, men;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void ref_axis(input int pos, input int dir, input int s, input int lim,
                                   output int npos, output int ndir);
    npos = pos;
    ndir = dir;
`ifdef SQ_CTRL_WRAP_EN
    if (dir == 1) npos = (pos + s > lim) ? pos + s - lim - 1 : pos + s;
    else          npos = (pos < s) ? pos + lim + 1 - s : pos - s;
`else
    if (s != 0) begin
      if (dir == 1) begin
        if (pos + s >= lim) begin npos = lim; ndir = 0; end
        else npos = pos + s;
      end else begin
        if (pos <= s) begin npos = 0; ndir = 1; end
        else npos = pos - s;
      end
    end
`endif
  endfunction

  function automatic int min15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // One vga_vs low pulse; drop_at>0 releases enable after that many clocks.
  task automatic run_frame(input string tag, input int drop_at, output int n_upd);
    int  px, py, lat, nx, ny, ndx, ndy;
    logic exp_upd;
    exp_upd = 1'b0;
    if (men == 1) begin
      if (mcnt == int'(bus.frame_div)) begin mcnt = 0; exp_upd = 1'b1; end
      else mcnt = (mcnt + 1) % 16;
    end
    px = mx;
    py = my;
    if (exp_upd) begin
      ref_axis(mx, mdx, int'(bus.step), LX, nx, ndx);
      ref_axis(my, mdy, int'(bus.step), LY, ny, ndy);
      mx = nx; mdx = ndx; my = ny; mdy = ndy;
    end
    n_upd = 0;
    lat   = 0;
    @(negedge clk);
    bus.vga_vs = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) bus.vga_vs = 1'b1;
      if (i == 4) chk({tag, " busy"}, bus.busy, exp_upd);
      if (i == 5) begin
        chk({tag, " hold_x"}, bus.sq_x, px);
        chk({tag, " hold_y"}, bus.sq_y, py);
      end
      if (i == drop_at) bus.enable = 1'b0;
      if (bus.frame_upd === 1'b1) begin
        n_upd++;
        if (lat == 0) lat = i;
      end
    end
    chk({tag, " pulses"}, n_upd, exp_upd ? 1 : 0);
    if (exp_upd) chk({tag, " latency"}, lat, 6);
    chk({tag, " sq_x"}, bus.sq_x, mx);
    chk({tag, " sq_y"}, bus.sq_y, my);
    chk({tag, " dir_x"}, bus.dir_x, mdx);
    chk({tag, " dir_y"}, bus.dir_y, mdy);
  endtask

  task automatic set_en(input logic v);
    @(negedge clk);
    bus.enable = v;
    men = v ? 1 : 0;
    if (!v) mcnt = 0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int n, tot, pat, guard, nrst;
    rst_n         = 1'b0;
    bus.vga_vs    = 1'b1;
    bus.enable    = 1'b0;
    bus.step      = 4'd0;
    bus.frame_div = 4'd0;
    mx = 165; my = 61; mdx = 1; mdy = 1; mcnt = 0; men = 0;

    #12;
    chk("rst sq_x", bus.sq_x, 165);
    chk("rst sq_y", bus.sq_y, 61);
    chk("rst dir_x", bus.dir_x, 1);
    chk("rst dir_y", bus.dir_y, 1);
    chk("rst frame_upd", bus.frame_upd, 0);
    chk("rst busy", bus.busy, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Disabled controller ignores frames
    run_frame("disabled", 0, n);

    // Basic update
    set_en(1'b1);
    bus.step = 4'd5;
    run_frame("basic", 0, n);
    chk("basic x170", bus.sq_x, 170);
    chk("basic y66", bus.sq_y, 66);

    // Walk X up to 328, then hit the right limit
    guard = 0;
    while (mx < 328 && guard < 30) begin
      bus.step = 4'(min15(328 - mx));
      run_frame("walk_x", 0, n);
      guard++;
    end
    chk("walk_x at 328", bus.sq_x, 328);
    bus.step = 4'd5;
    run_frame("edge_x", 0, n);
`ifdef SQ_CTRL_WRAP_EN
    chk("edge_x wrap", bus.sq_x, 2);
    chk("edge_x dir", bus.dir_x, 1);
    run_frame("edge_x2", 0, n);
    chk("edge_x2 pos", bus.sq_x, 7);
`else
    chk("edge_x bounce", bus.sq_x, 330);
    chk("edge_x dir", bus.dir_x, 0);
    run_frame("edge_x2", 0, n);
    chk("edge_x2 pos", bus.sq_x, 325);
`endif

    // Y edge case
    guard = 0;
`ifdef SQ_CTRL_WRAP_EN
    while (my != 120 && guard < 60) begin
      bus.step = (my < 120) ? 4'(min15(120 - my)) : 4'd15;
      run_frame("walk_y", 0, n);
      guard++;
    end
    chk("walk_y at 120", bus.sq_y, 120);
    bus.step = 4'd4;
    run_frame("edge_y", 0, n);
    chk("edge_y wrap", bus.sq_y, 1);
    chk("edge_y dir", bus.dir_y, 1);
`else
    while (!(mdy == 0 && my == 3) && guard < 60) begin
      if (mdy == 1 || my < 3) bus.step = 4'd15;
      else                    bus.step = 4'(min15(my - 3));
      run_frame("walk_y", 0, n);
      guard++;
    end
    chk("walk_y at 3", bus.sq_y, 3);
    chk("walk_y dir", bus.dir_y, 0);
    bus.step = 4'd4;
    run_frame("edge_y", 0, n);
    chk("edge_y bounce", bus.sq_y, 0);
    chk("edge_y dir", bus.dir_y, 1);
`endif

    // Frame division by 3
    bus.frame_div = 4'd2;
    bus.step      = 4'd1;
    pat = 0;
    for (int f = 0; f < 6; f++) begin
      run_frame("fdiv", 0, n);
      if (n > 0) pat = pat | (1 << f);
    end
    chk("fdiv pattern", pat, 32'b100100);
    bus.frame_div = 4'd0;

    // Enable dropped in CALC_Y: update completes, then idle
    bus.step = 4'd3;
    run_frame("drop_en", 4, n);
    men = 0;
    mcnt = 0;
    chk("drop_en busy", bus.busy, 0);
    run_frame("after_drop", 0, n);
    set_en(1'b1);

    // Reset while in CALC_X
    bus.step = 4'd7;
    nrst = 0;
    @(negedge clk);
    bus.vga_vs = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      #1;
      if (bus.frame_upd === 1'b1) nrst++;
      if (i == 3) begin
        bus.vga_vs = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst sq_x", bus.sq_x, 165);
        chk("midrst sq_y", bus.sq_y, 61);
        chk("midrst dir_x", bus.dir_x, 1);
        chk("midrst busy", bus.busy, 0);
        chk("midrst frame_upd", bus.frame_upd, 0);
      end
      if (i == 5) rst_n = 1'b1;
    end
    chk("midrst no pulse", nrst, 0);
    chk("midrst hold x", bus.sq_x, 165);
    mx = 165; my = 61; mdx = 1; mdy = 1; mcnt = 0;

    // Step 0 holds position but still pulses
    bus.step = 4'd0;
    tot = 0;
    for (int f = 0; f < 3; f++) begin
      run_frame("hold", 0, n);
      tot += n;
    end
    chk("hold pulses", tot, 3);
    chk("hold x", bus.sq_x, 165);
    chk("hold y", bus.sq_y, 61);

    // Random frames
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 7) == 0) set_en(men == 0);
      bus.step      = 4'($urandom_range(0, 15));
      bus.frame_div = 4'($urandom_range(0, 2));
      run_frame("rand", 0, n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
